strobe_gen: RTL and testbench



---
 rtl/hcsr04_pkg.sv | 12 +
 rtl/strobe_ch.sv | 59 +++++
 rtl/strobe_gen.sv | 48 ++++
 tb/tb_strobe_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared constants for the HC-SR04 ranging slice: strobe modes and the per-cm divisor.
package hcsr04_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  // 50 MHz / 2941 = 17.001 kHz, one tick per 58.82 us (1 cm round trip)
  localparam int unsigned DIV_CM_50MHZ = 2941;

endpackage

// File: rtl/strobe_ch.sv
// One strobe channel: programmable divisor, pausable counter, one-shot latch.
module strobe_ch
  import hcsr04_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DIV_DEF = DIV_CM_50MHZ
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             I_EN,
  input  logic             I_CLR,
  input  logic             I_MODE,
  input  logic             I_WR,
  input  logic [CNT_W-1:0] I_WR_DIV,
  output logic             O_ST,
  output logic             O_DONE
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term_c;
  logic             done;

  // div = 0 is treated as div = 1, so the terminal count never underflows
  assign term_c = (div == '0) ? '0 : div - CNT_W'(1);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      div  <= CNT_W'(DIV_DEF);
      cnt  <= '0;
      done <= 1'b0;
      O_ST <= 1'b0;
    end else begin
      if (I_WR) begin
        div <= I_WR_DIV;
      end
      if (I_CLR) begin
        cnt  <= '0;
        done <= 1'b0;
        O_ST <= 1'b0;
      end else if (!I_EN || done) begin
        O_ST <= 1'b0;
      end else if (cnt >= term_c) begin
        // >= lets a shrunken divisor fire immediately instead of overrunning
        cnt  <= '0;
        O_ST <= 1'b1;
        if (mode_e'(I_MODE) == MODE_ONESHOT) begin
          done <= 1'b1;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        O_ST <= 1'b0;
      end
    end
  end

  assign O_DONE = done;

endmodule

// File: rtl/strobe_gen.sv
// Multi-channel programmable strobe generator: divisor write decode plus NUM_CH channels.
module strobe_gen
  import hcsr04_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned CNT_W   = 16,
  parameter  int unsigned DIV_DEF = DIV_CM_50MHZ,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [NUM_CH-1:0] I_EN,
  input  logic [NUM_CH-1:0] I_CLR,
  input  logic [NUM_CH-1:0] I_MODE,
  input  logic              I_WR,
  input  logic [CH_W-1:0]   I_WR_CH,
  input  logic [CNT_W-1:0]  I_WR_DIV,
  output logic [NUM_CH-1:0] O_ST,
  output logic [NUM_CH-1:0] O_ACT
);

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] done;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Out-of-range channel numbers match no instance and are dropped
    assign wr_hit[c] = I_WR && (I_WR_CH == CH_W'(c));

    strobe_ch #(
      .CNT_W   (CNT_W),
      .DIV_DEF (DIV_DEF)
    ) u_ch (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .I_EN     (I_EN[c]),
      .I_CLR    (I_CLR[c]),
      .I_MODE   (I_MODE[c]),
      .I_WR     (wr_hit[c]),
      .I_WR_DIV (I_WR_DIV),
      .O_ST     (O_ST[c]),
      .O_DONE   (done[c])
    );
  end

  // Activity follows the enable directly; forced low while reset is held
  assign O_ACT = I_EN & ~done & {NUM_CH{RST_n}};

endmodule

// File: tb/tb_strobe_gen.sv
// Directed + randomized bench for strobe_gen against a per-channel progress model.
module tb_strobe_gen;

  localparam int unsigned NC   = 3;
  localparam int unsigned CW   = 2;
  localparam int unsigned NW   = 16;
  localparam int unsigned DDEF = 2941;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic [NC-1:0] en, clr, mode;
  logic          wr;
  logic [CW-1:0] wr_ch;
  logic [NW-1:0] wr_div;
  logic [NC-1:0] st, act;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  int m_div  [NC];
  int m_prog [NC];
  bit m_done [NC];
  bit m_st   [NC];
  int pulses [NC];
  int first  [NC];

  strobe_gen #(.NUM_CH(NC), .CNT_W(NW), .DIV_DEF(DDEF)) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .I_EN     (en),
    .I_CLR    (clr),
    .I_MODE   (mode),
    .I_WR     (wr),
    .I_WR_CH  (wr_ch),
    .I_WR_DIV (wr_div),
    .O_ST     (st),
    .O_ACT    (act)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_div[c] = DDEF; m_prog[c] = 0; m_done[c] = 0; m_st[c] = 0;
    end
  endfunction

  // Each channel counts enabled edges since its last strobe/restart and
  // strobes once that tally reaches the effective period max(div,1).
  function automatic void model_edge();
    int p;
    for (int c = 0; c < NC; c++) begin
      p = (m_div[c] == 0) ? 1 : m_div[c];
      if (clr[c]) begin
        m_prog[c] = 0; m_done[c] = 0; m_st[c] = 0;
      end else if (!en[c] || m_done[c]) begin
        m_st[c] = 0;
      end else if (m_prog[c] + 1 >= p) begin
        m_prog[c] = 0; m_st[c] = 1;
        if (mode[c]) m_done[c] = 1;
      end else begin
        m_prog[c] = m_prog[c] + 1; m_st[c] = 0;
      end
    end
    if (wr && int'(wr_ch) < NC) m_div[int'(wr_ch)] = int'(wr_div);
  endfunction

  function automatic logic [NC-1:0] exp_st();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_st[c];
    return v;
  endfunction

  function automatic logic [NC-1:0] exp_act();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = en[c] & ~m_done[c];
    return v;
  endfunction

  task automatic clear_tally();
    edge_no = 0;
    for (int c = 0; c < NC; c++) begin pulses[c] = 0; first[c] = 0; end
  endtask

  // One clock edge: advance the model, then compare just after the edge
  task automatic cyc();
    @(posedge CLK);
    model_edge();
    edge_no++;
    #1;
    check("st", 32'(st), 32'(exp_st()));
    check("act", 32'(act), 32'(exp_act()));
    for (int c = 0; c < NC; c++) begin
      if (st[c]) begin
        pulses[c]++;
        if (first[c] == 0) first[c] = edge_no;
      end
    end
  endtask

  task automatic write_div(input int ch, input int val);
    wr = 1'b1; wr_ch = CW'(ch); wr_div = NW'(val);
    cyc();
    wr = 1'b0;
  endtask

  initial begin
    int p1;
    RST_n = 1'b0; en = 3'b001; clr = '0; mode = '0;
    wr = 1'b0; wr_ch = '0; wr_div = '0;
    model_reset();
    clear_tally();
    #12;
    check("rst_st", 32'(st), 32'(0));
    check("rst_act", 32'(act), 32'(0));
    @(negedge CLK);
    RST_n = 1'b1;

    // Default divisor on channel 0
    for (int i = 0; i < 8823; i++) cyc();
    check("def_first_edge", 32'(first[0]), 32'(2941));
    check("def_pulse_cnt0", 32'(pulses[0]), 32'(3));
    check("def_pulse_cnt1", 32'(pulses[1]), 32'(0));
    check("def_act", 32'(act), 32'(3'b001));

    // One-shot on channel 1, then re-arm
    write_div(1, 5);
    en[1] = 1'b1; mode[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("os_st1", 32'(st[1]), 32'(i == 5));
    end
    check("os_act1_fall", 32'(act[1]), 32'(0));
    p1 = pulses[1];
    for (int i = 0; i < 6; i++) cyc();
    check("os_no_more", 32'(pulses[1]), 32'(p1));
    clr[1] = 1'b1;
    cyc();
    clr[1] = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("os_rearm_early", 32'(st[1]), 32'(0));
    cyc();
    check("os_rearm_pulse", 32'(st[1]), 32'(1));

    // Pause at cnt = 4 with div = 10
    en = '0; clr = 3'b111;
    write_div(0, 10);
    clr = '0; en = 3'b001;
    for (int i = 0; i < 4; i++) cyc();
    en = '0;
    for (int i = 0; i < 3; i++) cyc();
    en = 3'b001;
    for (int i = 0; i < 5; i++) cyc();
    check("pause_12", 32'(st[0]), 32'(0));
    cyc();
    check("pause_13", 32'(st[0]), 32'(1));

    // Shrink divisor below the running count
    en = '0; clr = 3'b001;
    write_div(0, 100);
    clr = '0; en = 3'b001;
    for (int i = 0; i < 60; i++) cyc();
    write_div(0, 20);
    check("shrink_write_edge", 32'(st[0]), 32'(0));
    cyc();
    check("shrink_fire", 32'(st[0]), 32'(1));
    for (int i = 0; i < 19; i++) cyc();
    check("shrink_gap", 32'(st[0]), 32'(0));
    cyc();
    check("shrink_period", 32'(st[0]), 32'(1));

    // div = 0 / div = 1, then an out-of-range write
    en = '0; mode = '0;
    write_div(0, 0);
    write_div(2, 1);
    clr = 3'b101;
    cyc();
    clr = '0; en = 3'b101;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("p1_high", 32'({st[2], st[0]}), 32'(2'b11));
    end
    write_div(3, 7);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bad_ch_high", 32'({st[2], st[0]}), 32'(2'b11));
    end

    // Async reset mid-count with channel 1 finished
    en = '0; clr = 3'b111;
    write_div(0, 10);
    clr = '0; mode = 3'b010;
    write_div(1, 2);
    en = 3'b011;
    for (int i = 0; i < 7; i++) cyc();
    check("pre_rst_done1", 32'(act[1]), 32'(0));
    #3;
    RST_n = 1'b0;
    model_reset();
    #1;
    check("async_st", 32'(st), 32'(0));
    check("async_act", 32'(act), 32'(0));
    #10;
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    check("post_rst_act", 32'(act), 32'(3'b011));
    clear_tally();
    for (int i = 0; i < 2941; i++) cyc();
    check("post_rst_div0", 32'(first[0]), 32'(2941));
    check("post_rst_div1", 32'(first[1]), 32'(2941));

    // Randomized traffic with small divisors
    en = '0; clr = 3'b111;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      en = NC'($urandom);
      for (int c = 0; c < NC; c++) clr[c] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) mode = NC'($urandom);
      wr = ($urandom_range(0, 7) == 0);
      wr_ch = CW'($urandom_range(0, 3));
      wr_div = NW'($urandom_range(0, 12));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
